spi_word_master: RTL and testbench

SPI_WORD_MASTER -- requirements
Module: spi_word_master

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_sclk_gen.sv | 71 +++++++
 rtl/spi_word_master.sv | 216 +++++++++++++++++++++
 tb/tb_spi_word_master.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI word master and its SCLK generator.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } spi_state_e;

   // {CPOL, CPHA}
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   // Bits needed for a counter that must hold values 0..max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period down-counter producing SCLK and its leading/trailing edge strobes.
module spi_sclk_gen
   import spi_pkg::*;
#(
   parameter int HALF = 10
)
(
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic en,
   input  logic last,
   input  logic park,
   input  logic cpol,
   output logic lead_stb,
   output logic trail_stb,
   output logic period_done,
   output logic sclk
);

   localparam int CW = cnt_width(HALF - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;
   logic          sclk_q, sclk_d;
   logic          tc;

   always_comb begin
      tc          = en && (cnt_q == '0);
      trail_stb   = tc && !phase_q;
      period_done = tc && phase_q;
      // the edge that would open another period is suppressed after the last bit
      lead_stb    = start || (period_done && !last);

      cnt_d   = cnt_q;
      phase_d = phase_q;
      sclk_d  = sclk_q;

      if (start) begin
         cnt_d   = HALF_M1;
         phase_d = 1'b0;
      end else if (tc) begin
         cnt_d   = HALF_M1;
         phase_d = !phase_q;
      end else if (en) begin
         cnt_d = cnt_q - CW'(1);
      end

      if (park || trail_stb) begin
         sclk_d = cpol;
      end else if (lead_stb) begin
         sclk_d = !cpol;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
         sclk_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         sclk_q  <= sclk_d;
      end
   end

   assign sclk = sclk_q;

endmodule

// File: rtl/spi_word_master.sv
// SPI master sending one right-aligned word of 1..DATA_WIDTH/8 bytes per request.
//
// state | meaning
// IDLE  | waiting for is_data_ready; all cs high, mosi 0
// SETUP | cs asserted, half period before the first SCLK edge
// SHIFT | 8*nbytes SCLK periods of shifting
// HOLD  | cs still asserted, half period after the last period
// GAP   | cs released, half period before the next accept
module spi_word_master
   import spi_pkg::*;
#(
   parameter  int SCLK_DIVIDER = 20,
   parameter  int DATA_WIDTH   = 32,
   parameter  int NUM_CS       = 1,
   localparam int NBW          = $clog2(DATA_WIDTH / 8) + 1,
   localparam int CSW          = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  is_data_ready,
   input  logic [NBW-1:0]        nbytes,
   input  logic [1:0]            mode,
   input  logic [CSW-1:0]        cs_sel,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  miso,
   output logic                  mosi,
   output logic                  sclk,
   output logic [NUM_CS-1:0]     cs,
   output logic                  is_busy,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid
);

   localparam int HALF = SCLK_DIVIDER / 2;
   localparam int MAXB = DATA_WIDTH / 8;
   localparam int TW   = cnt_width(HALF - 1);
   localparam int BW   = cnt_width(DATA_WIDTH);
   localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);

   spi_state_e            state_q, state_d;
   logic [TW-1:0]         tmr_q, tmr_d;
   logic [BW-1:0]         bits_q, bits_d;
   logic [1:0]            mode_q, mode_d;
   logic [NUM_CS-1:0]     cs_q, cs_d;
   logic [DATA_WIDTH-1:0] tx_q, tx_d;
   logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  mosi_q, mosi_d;

   logic                  accept;
   logic [NBW-1:0]        nb_eff;
   logic [BW-1:0]         bits_load;
   logic [DATA_WIDTH-1:0] tx_aligned;
   logic                  start, en, last, cpol_nxt;
   logic                  lead_stb, trail_stb, period_done;
   logic                  shift_out, sample_in;

   assign accept = (state_q == IDLE) && is_data_ready;

   always_comb begin
      if (nbytes == '0) begin
         nb_eff = NBW'(1);
      end else if (nbytes > NBW'(MAXB)) begin
         nb_eff = NBW'(MAXB);
      end else begin
         nb_eff = nbytes;
      end
   end

   // left-align so the MSB to send always sits at the top of the shift register
   assign bits_load  = BW'({nb_eff, 3'b000});
   assign tx_aligned = data << (BW'(DATA_WIDTH) - bits_load);

   assign start    = (state_q == SETUP) && (tmr_q == '0);
   assign en       = (state_q == SHIFT);
   assign last     = (bits_q == BW'(1));
   assign cpol_nxt = accept ? mode[1] : mode_q[1];

   spi_sclk_gen #(
      .HALF (HALF)
   ) u_sclk_gen (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .en          (en),
      .last        (last),
      .park        (accept),
      .cpol        (cpol_nxt),
      .lead_stb    (lead_stb),
      .trail_stb   (trail_stb),
      .period_done (period_done),
      .sclk        (sclk)
   );

   assign shift_out = mode_q[0] ? lead_stb  : trail_stb;
   assign sample_in = mode_q[0] ? trail_stb : lead_stb;

   always_comb begin
      state_d    = state_q;
      tmr_d      = tmr_q;
      bits_d     = bits_q;
      mode_d     = mode_q;
      cs_d       = cs_q;
      tx_d       = tx_q;
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      mosi_d     = mosi_q;

      if (shift_out) begin
         mosi_d = tx_q[DATA_WIDTH-1];
         tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
      end
      if (sample_in) begin
         rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], miso};
      end

      case (state_q)
         IDLE: begin
            mosi_d = 1'b0;
            cs_d   = '1;
            if (is_data_ready) begin
               state_d = SETUP;
               tmr_d   = HALF_M1;
               bits_d  = bits_load;
               mode_d  = mode;
               cs_d    = ~(NUM_CS'(1) << cs_sel);
               rx_sh_d = '0;
               // CPHA=0 must have the first bit on the wire before the first edge
               if (mode[0]) begin
                  mosi_d = 1'b0;
                  tx_d   = tx_aligned;
               end else begin
                  mosi_d = tx_aligned[DATA_WIDTH-1];
                  tx_d   = {tx_aligned[DATA_WIDTH-2:0], 1'b0};
               end
            end
         end
         SETUP: begin
            if (tmr_q == '0) begin
               state_d = SHIFT;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         SHIFT: begin
            if (period_done) begin
               bits_d = bits_q - BW'(1);
               if (last) begin
                  state_d = HOLD;
                  tmr_d   = HALF_M1;
               end
            end
         end
         HOLD: begin
            if (tmr_q == '0) begin
               state_d    = GAP;
               tmr_d      = HALF_M1;
               cs_d       = '1;
               mosi_d     = 1'b0;
               rx_data_d  = rx_sh_q;
               rx_valid_d = 1'b1;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         GAP: begin
            if (tmr_q == '0) begin
               state_d = IDLE;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cs_d    = '1;
            mosi_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         tmr_q      <= '0;
         bits_q     <= '0;
         mode_q     <= MODE0;
         cs_q       <= '1;
         tx_q       <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         mosi_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         bits_q     <= bits_d;
         mode_q     <= mode_d;
         cs_q       <= cs_d;
         tx_q       <= tx_d;
         rx_sh_q    <= rx_sh_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         mosi_q     <= mosi_d;
      end
   end

   assign mosi     = mosi_q;
   assign cs       = cs_q;
   assign is_busy  = (state_q != IDLE);
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_word_master.sv
// Randomized bench for spi_word_master: a bus monitor reconstructs each transfer
// and compares it with what the word, byte count and mode should produce.
module tb_spi_word_master;

   localparam int DIV = 4;
   localparam int DW  = 32;
   localparam int NCS = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           is_data_ready = 1'b0;
   logic [2:0]     nbytes = '0;
   logic [1:0]     mode = '0;
   logic [1:0]     cs_sel = '0;
   logic [DW-1:0]  data = '0;
   logic           miso, mosi, sclk, is_busy, rx_valid;
   logic [NCS-1:0] cs;
   logic [DW-1:0]  rx_data;
   logic           inv = 1'b0;

   // slave echoes mosi, optionally inverted
   assign miso = mosi ^ inv;

   always #5 clk = ~clk;

   spi_word_master #(
      .SCLK_DIVIDER (DIV),
      .DATA_WIDTH   (DW),
      .NUM_CS       (NCS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .is_data_ready (is_data_ready),
      .nbytes        (nbytes),
      .mode          (mode),
      .cs_sel        (cs_sel),
      .data          (data),
      .miso          (miso),
      .mosi          (mosi),
      .sclk          (sclk),
      .cs            (cs),
      .is_busy       (is_busy),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   logic [1:0]    cur_mode = '0;
   logic [1:0]    cur_sel  = '0;
   int            cs_low_cnt = 0, cs_bad = 0, busy_cnt = 0, rxv_cnt = 0;
   int            edge_cnt = 0, cap_cnt = 0, mosi_bad = 0;
   logic [63:0]   cap = '0;
   logic [DW-1:0] rx_seen = '0;
   logic          prev_sclk = 1'b0, prev_low = 1'b0, cur_low, samp_lvl;

   always @(negedge clk) begin
      samp_lvl = cur_mode[0] ? cur_mode[1] : ~cur_mode[1];
      cur_low  = (cs[cur_sel] == 1'b0);
      if (cur_low) cs_low_cnt++;
      if ((cs | (NCS'(1) << cur_sel)) != {NCS{1'b1}}) cs_bad++;
      if (is_busy) busy_cnt++;
      if (rx_valid) begin
         rxv_cnt++;
         rx_seen = rx_data;
      end
      if ((&cs) && mosi) mosi_bad++;
      if (prev_low && (sclk != prev_sclk)) begin
         edge_cnt++;
         if (sclk == samp_lvl) begin
            cap = {cap[62:0], mosi};
            cap_cnt++;
         end
      end
      prev_sclk = sclk;
      prev_low  = cur_low;
   end

   task automatic xfer(input logic [2:0] n, input logic [1:0] m, input logic [1:0] sel,
                       input logic [31:0] d, input logic iv, input logic repulse);
      int          ne;
      int          b_cs, b_bad, b_busy, b_rxv, b_edge, b_cap, b_mb;
      logic [63:0] mask;
      logic [31:0] exp_tx, exp_rx;
      ne     = (n == 0) ? 1 : ((n > 4) ? 4 : int'(n));
      mask   = (64'd1 << (8 * ne)) - 64'd1;
      exp_tx = d & mask[31:0];
      exp_rx = iv ? (~d & mask[31:0]) : exp_tx;
      b_cs = cs_low_cnt; b_bad = cs_bad; b_busy = busy_cnt; b_rxv = rxv_cnt;
      b_edge = edge_cnt; b_cap = cap_cnt; b_mb = mosi_bad;
      cur_mode = m; cur_sel = sel; inv = iv;
      nbytes = n; mode = m; cs_sel = sel; data = d; is_data_ready = 1'b1;
      @(negedge clk);
      is_data_ready = 1'b0;
      chk("sclk_at_setup", sclk, m[1]);
      chk("busy_after_accept", is_busy, 1'b1);
      // scramble the request inputs; the transfer must use its captured copies
      mode = 2'($urandom); data = $urandom; nbytes = 3'($urandom); cs_sel = 2'($urandom);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (repulse && i == 10) is_data_ready = 1'b1;
         if (repulse && i == 11) is_data_ready = 1'b0;
         if (!is_busy) break;
      end
      is_data_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("busy_done", {is_busy, cs}, {1'b0, {NCS{1'b1}}});
      chk("bit_count", cap_cnt - b_cap, 8 * ne);
      chk("mosi_word", cap & mask, {32'd0, exp_tx});
      chk("sclk_edges", edge_cnt - b_edge, 16 * ne);
      chk("cs_low_cycles", cs_low_cnt - b_cs, (8 * ne + 1) * DIV);
      chk("cs_other_low", cs_bad - b_bad, 0);
      chk("busy_cycles", busy_cnt - b_busy, 8 * ne * DIV + 3 * DIV / 2);
      chk("rx_valid_pulses", rxv_cnt - b_rxv, 1);
      chk("rx_data", rx_seen, exp_rx);
      chk("mosi_idle_zero", mosi_bad - b_mb, 0);
      chk("sclk_idle", sclk, m[1]);
   endtask

   task automatic reset_mid_xfer();
      int b_cap, b_rxv;
      b_cap = cap_cnt;
      cur_mode = 2'b00; cur_sel = 2'd1; inv = 1'b0;
      nbytes = 3'd2; mode = 2'b00; cs_sel = 2'd1; data = $urandom; is_data_ready = 1'b1;
      @(negedge clk);
      is_data_ready = 1'b0;
      for (int i = 0; i < 500 && (cap_cnt - b_cap) < 5; i++) @(negedge clk);
      chk("rst_reached_bit5", cap_cnt - b_cap, 5);
      b_rxv = rxv_cnt;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_cs", cs, {NCS{1'b1}});
      chk("rst_sclk", sclk, 1'b0);
      chk("rst_mosi", mosi, 1'b0);
      chk("rst_busy", is_busy, 1'b0);
      chk("rst_rx_valid", rx_valid, 1'b0);
      chk("rst_rx_data", rx_data, '0);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      chk("rst_no_rx_valid", rxv_cnt - b_rxv, 0);
      chk("rst_stays_idle", {is_busy, cs}, {1'b0, {NCS{1'b1}}});
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_cs", cs, {NCS{1'b1}});
      chk("reset_sclk", sclk, 1'b0);
      chk("reset_outputs", {mosi, is_busy, rx_valid}, 3'b000);
      chk("reset_rx_data", rx_data, '0);
      rst = 1'b0;
      @(negedge clk);

      xfer(3'd1, 2'b00, 2'd0, 32'h0000_00A5, 1'b0, 1'b0);
      xfer(3'd4, 2'b11, 2'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
      xfer(3'd2, 2'b01, 2'd1, 32'h0001_2345, 1'b0, 1'b0);
      xfer(3'd2, 2'b10, 2'd2, $urandom, 1'b0, 1'b1);
      xfer(3'd0, 2'b00, 2'd3, 32'h1234_56C3, 1'b0, 1'b0);
      xfer(3'd7, 2'b01, 2'd0, 32'h8BAD_F00D, 1'b0, 1'b0);
      xfer(3'd3, 2'b11, 2'd1, 32'h00F0_0F5A, 1'b1, 1'b0);

      for (int k = 0; k < 20; k++) begin
         xfer(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), $urandom,
              1'($urandom), 1'($urandom_range(0, 3) == 0));
      end

      reset_mid_xfer();
      xfer(3'd1, 2'b10, 2'd3, 32'h0000_003C, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
